pipe_stage_buf: RTL
===================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter WIDTH, default 32, width of one lane in bits.
REQ-002 Parameter LANES, default 5, number of lanes carried per entry (ALU, MEM, INS, REG1, REG2).
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 clrn  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream entry present.
REQ-007 in_ready  output  1  stage can accept an entry this cycle.
REQ-008 in_data  input  LANES*WIDTH  upstream entry; lane k at bits [k*WIDTH +: WIDTH].
REQ-009 flush  input  1  discard all held entries (branch/PCSrc redirect).
REQ-010 out_valid  output  1  downstream entry present.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_data  output  LANES*WIDTH  held entry, same lane packing as in_data.
REQ-013 occupancy  output  2  entries held: 0, 1 or 2.
REQ-014 stall_cnt  output  CNT_W  count of downstream-stall cycles.

Function
REQ-015 The block SHALL hold two entry registers: main (drives out_data) and skid.
REQ-016 The FSM SHALL have states EMPTY, ONE and TWO; occupancy SHALL equal 0, 1 and 2 respectively.
REQ-017 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-018 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, driven from state only (no combinational path from out_ready).
REQ-019 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-020 EMPTY: in_fire -> main<=in_data, go ONE; otherwise stay.
REQ-021 ONE: in_fire & out_fire -> main<=in_data, stay ONE; in_fire only -> skid<=in_data, go TWO; out_fire only -> go EMPTY.
REQ-022 TWO: out_fire -> main<=skid, go ONE; otherwise hold.
REQ-023 Latency: an entry accepted at edge N SHALL appear on out_data after edge N (visible in cycle N+1) when the stage was EMPTY or draining.
REQ-024 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush.
REQ-025 flush SHALL force EMPTY at the next edge, overriding any simultaneous in_fire or out_fire; the in_fire entry of that cycle SHALL be discarded.
REQ-026 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-027 stall_cnt SHALL increment by 1 on every edge with out_valid=1 and out_ready=0, and saturate at 2^CNT_W-1.
REQ-028 flush SHALL NOT clear stall_cnt.
REQ-029 Data registers SHALL NOT be updated in cycles without a corresponding fire (power; no X propagation into main/skid).

Reset
REQ-030 While clrn=0: state EMPTY, in_ready=1, out_valid=0, occupancy=0, stall_cnt=0, main and skid = 0, out_data = 0.
REQ-031 Reset asserted mid-transfer SHALL discard all held entries immediately (asynchronous), without waiting for clk.
REQ-032 First accept after release SHALL occur no earlier than the first rising edge with clrn=1.

Structure
REQ-033 State encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and default WIDTH/LANES SHALL live in the shared CPU package, reused by the control unit for stall/flush handling.
REQ-034 Lane index constants (LANE_ALU=0, LANE_MEM=1, LANE_INS=2, LANE_REG1=3, LANE_REG2=4) SHALL live in the same package.
REQ-035 One sub-module is natural: sat_counter (parameter W; inc, count; async active-low clear) for stall_cnt.
REQ-036 The block SHALL replace the five per-lane pipeline caches; no per-lane logic beyond packing.

Verification
REQ-037 Streaming: out_ready=1, in_valid=1 with in_data lane0 = 1,2,3,4 on consecutive edges -> out_data lane0 = 1,2,3,4 one cycle later each, occupancy stays 1, stall_cnt=0.
REQ-038 Backpressure: out_ready=0, push A=0x11 then B=0x22 -> occupancy 2, in_ready=0, out_data=0x11; third push 0x33 not accepted; raise out_ready -> outputs 0x11, 0x22, then 0x33 once re-presented.
REQ-039 Flush collision: state TWO, flush=1 with in_valid=1 and out_ready=1 same cycle -> next cycle occupancy=0, out_valid=0, in_ready=1; flushed data never appears.
REQ-040 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15; flush leaves it 15.
REQ-041 Async reset: state TWO, drive clrn=0 between edges -> out_valid=0, occupancy=0, out_data=0 before the next clk edge; stall_cnt=0.
REQ-042 Parameter sweep: WIDTH=8, LANES=1 and WIDTH=32, LANES=5 both pass REQ-037..REQ-041 with a scoreboard checking order and no loss.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared CPU pipeline package: buffer state encoding, default entry
// geometry and lane index constants used by the stage buffer and the
// control unit's stall/flush handling.
package pipe_stage_buf_pkg;

  // Default geometry of one pipeline entry
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_LANES = 5;

  // Lane positions inside a packed entry
  localparam int LANE_ALU  = 0;
  localparam int LANE_MEM  = 1;
  localparam int LANE_INS  = 2;
  localparam int LANE_REG1 = 3;
  localparam int LANE_REG2 = 4;

  // Buffer fill state; the encoding doubles as the occupancy count
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on each enabled edge, sticking at the all-ones value
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer (main + skid register) carrying all
// lanes of one pipeline entry as a single packed word. in_ready depends
// on state only, so there is no combinational path from out_ready.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LANES = DEFAULT_LANES,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [1:0]             occupancy,
  output logic [CNT_W-1:0]       stall_cnt
);

  buf_state_t state;
  buf_state_t next_state;

  logic [LANES*WIDTH-1:0] main_q;
  logic [LANES*WIDTH-1:0] skid_q;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Handshake flags are decoded from the registered state only
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state)
      ST_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      ST_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_TWO: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next state and data-register load enables; flush wins over any fire
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          next_state   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
          next_state   = ST_ONE;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          next_state = ST_TWO;
        end else if (out_fire) begin
          next_state = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          next_state     = ST_ONE;
        end
      end
      default: begin
        next_state = ST_EMPTY;
      end
    endcase
    if (flush) begin
      next_state     = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= ST_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Entry registers only change on an accepted or forwarded entry
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign out_data = main_q;

  // Downstream stall cycles: entry offered but not taken
  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clrn (clrn),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule
